sync_updown_counter: RTL and testbench
======================================

// Module: sync_updown_counter
// PURPOSE
//   Parametrised, fully synchronous up/down counter with programmable modulus,
//   parallel load, count enable and a wrap-or-saturate end policy.
//   Next-generation replacement for the fixed 4-bit ripple down counter:
//   - every bit changes on clk only; no derived clocks;
//   - direction is selectable per cycle.
//   Used as the general counter/timer primitive in lab designs (decade counters, dividers, timers).
// PARAMETERS
//   WIDTH     4   counter width in bits; legal range 1..32
//   MODULUS   16  count range is 0..MODULUS-1; legal range 2..2**WIDTH
//   SATURATE  0   0 = wrap at the ends of the range; 1 = hold at the ends
//   Illegal WIDTH/MODULUS combinations are an elaboration error.
// PORTS
//   clk       in   1      sole clock; all state updates on posedge
//   rst       in   1      synchronous reset, active-high
//   en        in   1      count enable; takes one step per enabled cycle
//   up        in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      parallel load strobe
//   load_val  in   WIDTH  value to load
//   count     out  WIDTH  current count (registered)
//   limit     out  1      registered one-cycle pulse: a step hit an end of the range
//   zero      out  1      combinational: count == 0
//   max       out  1      combinational: count == MODULUS-1
// BEHAVIOUR
//   - Reset: rst sampled high at posedge -> count=0, limit=0 (so zero=1, max=0).
//     Reset applies from that edge regardless of en/load; there is no async path.
//   - Priority at each posedge: rst > load > en > hold.
//   - load=1:
//     - count <= load_val if load_val <= MODULUS-1, else count <= MODULUS-1 (clamped).
//     - limit <= 0.
//   - en=1, load=0, up=1:
//     - count < MODULUS-1: count+1, limit <= 0.
//     - count == MODULUS-1: SATURATE=0 -> count <= 0; SATURATE=1 -> hold. limit <= 1 in both cases.
//   - en=1, load=0, up=0:
//     - count > 0: count-1, limit <= 0.
//     - count == 0: SATURATE=0 -> count <= MODULUS-1; SATURATE=1 -> hold. limit <= 1 in both cases.
//   - en=0, load=0: count holds; limit <= 0.
//   - Timing and pulse width:
//     - Latency: count and limit reflect the step at the edge that samples en.
//     - limit is high for exactly one cycle per end event.
//     - In saturate mode, continued stepping into the end pulses limit on every enabled cycle.
//   - Direction: up may change on any cycle and takes effect at the next enabled edge.
//     There is no restriction on toggling it.
//   - Arithmetic: comparisons are against MODULUS-1 at WIDTH bits.
//     Carry out of WIDTH bits never reaches count; count is never >= MODULUS.
//   - zero/max decode the registered count combinationally; no added latency.
// TESTING
//   1. WIDTH=4, MODULUS=16, SATURATE=0:
//      rst 2 cycles, then en=1, up=0 for 17 cycles
//      -> count 0,15,14,...,0,15; limit pulses on the 0->15 steps only.
//   2. MODULUS=10, up=1, en=1 from reset
//      -> count 0..9,0; limit=1 only in the cycle count becomes 0 after 9; max=1 while count=9.
//   3. MODULUS=10, SATURATE=1: load 7, then up=1 for 5 cycles
//      -> count 8,9,9,9,9; limit pulses for 3 cycles.
//      Then up=0 -> count 8, limit=0.
//   4. load=1, load_val=12, MODULUS=10 -> count=9.
//      load and en high together with load_val=3, up=1 -> count=3 (load wins), limit=0.
//   5. Reset mid-count: count=6, en=1, assert rst for 1 cycle
//      -> count=0, limit=0 next edge; counting resumes from 0 the cycle after rst drops.
//   6. en toggled every other cycle with up alternating
//      -> count changes only on enabled edges, direction per sampled up.
//      Self-checking reference model compares every cycle.

Source files
------------

// File: rtl/sync_updown_counter_if.sv
// Control/status bundle for sync_updown_counter: step/load controls in,
// registered count and end-of-range flags out.
interface sync_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             limit;
    logic             zero;
    logic             max;

    modport master (
        output en, up, load, load_val,
        input  count, limit, zero, max
    );

    modport slave (
        input  en, up, load, load_val,
        output count, limit, zero, max
    );
endinterface

// File: rtl/sync_updown_counter.sv
// Fully synchronous up/down counter over 0..MODULUS-1 with clamped parallel
// load, count enable and wrap-or-saturate behaviour at the range ends.
module sync_updown_counter #(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    sync_updown_counter_if.slave bus
);
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sync_updown_counter: WIDTH out of range 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("sync_updown_counter: MODULUS out of range 2..2**WIDTH");
    end

    // Highest legal count; MODULUS may equal 2**WIDTH, so derive it before truncating.
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic             limit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            limit_q <= 1'b0;
        end else if (bus.load) begin
            count_q <= (bus.load_val > TOP) ? TOP : bus.load_val;
            limit_q <= 1'b0;
        end else if (bus.en) begin
            if (bus.up) begin
                if (count_q == TOP) begin
                    limit_q <= 1'b1;
                    if (!SATURATE) count_q <= '0;
                end else begin
                    count_q <= count_q + WIDTH'(1);
                    limit_q <= 1'b0;
                end
            end else begin
                if (count_q == '0) begin
                    limit_q <= 1'b1;
                    if (!SATURATE) count_q <= TOP;
                end else begin
                    count_q <= count_q - WIDTH'(1);
                    limit_q <= 1'b0;
                end
            end
        end else begin
            limit_q <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.limit = limit_q;
    assign bus.zero  = (count_q == '0);
    assign bus.max   = (count_q == TOP);
endmodule

// File: tb/tb_sync_updown_counter.sv
// Drives three counter configurations (mod16 wrap, mod10 wrap, mod10 saturate)
// and compares them against an arithmetic reference model.
module tb_sync_updown_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sync_updown_counter_if #(.WIDTH(4)) u0 ();
    sync_updown_counter_if #(.WIDTH(4)) u1 ();
    sync_updown_counter_if #(.WIDTH(4)) u2 ();

    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) d0 (.clk(clk), .rst(rst), .bus(u0));
    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) d1 (.clk(clk), .rst(rst), .bus(u1));
    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) d2 (.clk(clk), .rst(rst), .bus(u2));

    logic [3:0] cnt [3];
    logic       lim [3];
    logic       zr  [3];
    logic       mx  [3];
    assign cnt[0] = u0.count; assign lim[0] = u0.limit; assign zr[0] = u0.zero; assign mx[0] = u0.max;
    assign cnt[1] = u1.count; assign lim[1] = u1.limit; assign zr[1] = u1.zero; assign mx[1] = u1.max;
    assign cnt[2] = u2.count; assign lim[2] = u2.limit; assign zr[2] = u2.zero; assign mx[2] = u2.max;

    // Stimulus per DUT
    bit       e  [3];
    bit       u  [3];
    bit       l  [3];
    bit [3:0] lv [3];

    // Reference model state
    int unsigned mod [3] = '{16, 10, 10};
    bit          sat [3] = '{1'b0, 1'b0, 1'b1};
    int unsigned mc  [3];
    bit          ml  [3];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            e[i] = 1'b0; u[i] = 1'b0; l[i] = 1'b0; lv[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mc[i] = 0; ml[i] = 1'b0;
            end else if (l[i]) begin
                mc[i] = (int'(lv[i]) > mod[i] - 1) ? mod[i] - 1 : int'(lv[i]);
                ml[i] = 1'b0;
            end else if (e[i] && u[i]) begin
                ml[i] = (mc[i] == mod[i] - 1);
                if (!ml[i]) mc[i] = mc[i] + 1;
                else if (!sat[i]) mc[i] = 0;
            end else if (e[i]) begin
                ml[i] = (mc[i] == 0);
                if (!ml[i]) mc[i] = mc[i] - 1;
                else if (!sat[i]) mc[i] = mod[i] - 1;
            end else begin
                ml[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        u0.en = e[0]; u0.up = u[0]; u0.load = l[0]; u0.load_val = lv[0];
        u1.en = e[1]; u1.up = u[1]; u1.load = l[1]; u1.load_val = lv[1];
        u2.en = e[2]; u2.up = u[2]; u2.load = l[2]; u2.load_val = lv[2];
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < 3; i++) begin e[i] = 1'b1; u[i] = 1'b1; end
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (cnt[i] !== 4'd0 || lim[i] !== 1'b0 || zr[i] !== 1'b1 || mx[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d got count=%0d limit=%b zero=%b max=%b want 0/0/1/0",
                         i, cnt[i], lim[i], zr[i], mx[i]);
            end
        end
        idle();
    endtask

    task automatic test_down_wrap();
        idle();
        e[0] = 1'b1; u[0] = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            int  exp_c;
            bit  exp_l;
            tick();
            exp_c = (16 - k) % 16;
            exp_l = (k == 1 || k == 17);
            n_chk++;
            if (cnt[0] !== 4'(exp_c) || lim[0] !== exp_l) begin
                n_fail++;
                $display("FAIL down_wrap step %0d got count=%0d limit=%b want %0d/%b",
                         k, cnt[0], lim[0], exp_c, exp_l);
            end
        end
        idle();
    endtask

    task automatic test_up_mod10();
        idle();
        rst = 1'b1; tick(); rst = 1'b0;
        e[1] = 1'b1; u[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            int exp_c;
            tick();
            exp_c = k % 10;
            n_chk++;
            if (cnt[1] !== 4'(exp_c) || lim[1] !== (k == 10) || mx[1] !== (exp_c == 9)) begin
                n_fail++;
                $display("FAIL up_mod10 step %0d got count=%0d limit=%b max=%b want %0d/%b/%b",
                         k, cnt[1], lim[1], mx[1], exp_c, (k == 10), (exp_c == 9));
            end
        end
        idle();
    endtask

    task automatic test_saturate();
        int exp_c [5] = '{8, 9, 9, 9, 9};
        bit exp_l [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        idle();
        l[2] = 1'b1; lv[2] = 4'd7;
        tick();
        l[2] = 1'b0; e[2] = 1'b1; u[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_chk++;
            if (cnt[2] !== 4'(exp_c[k]) || lim[2] !== exp_l[k]) begin
                n_fail++;
                $display("FAIL saturate step %0d got count=%0d limit=%b want %0d/%b",
                         k, cnt[2], lim[2], exp_c[k], exp_l[k]);
            end
        end
        u[2] = 1'b0;
        tick();
        n_chk++;
        if (cnt[2] !== 4'd8 || lim[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate_down got count=%0d limit=%b want 8/0", cnt[2], lim[2]);
        end
        idle();
    endtask

    task automatic test_load();
        idle();
        l[1] = 1'b1; lv[1] = 4'd12;
        l[2] = 1'b1; lv[2] = 4'd15;
        tick();
        n_chk++;
        if (cnt[1] !== 4'd9 || cnt[2] !== 4'd9 || lim[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp got count1=%0d count2=%0d limit1=%b want 9/9/0", cnt[1], cnt[2], lim[1]);
        end
        // Count sits at 9, so an up step would hit the end; load must win.
        l[1] = 1'b1; e[1] = 1'b1; u[1] = 1'b1; lv[1] = 4'd3; l[2] = 1'b0;
        tick();
        n_chk++;
        if (cnt[1] !== 4'd3 || lim[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_priority got count=%0d limit=%b want 3/0", cnt[1], lim[1]);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        l[0] = 1'b1; lv[0] = 4'd6;
        tick();
        l[0] = 1'b0; e[0] = 1'b1; u[0] = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (cnt[0] !== 4'd0 || lim[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got count=%0d limit=%b want 0/0", cnt[0], lim[0]);
        end
        tick();
        n_chk++;
        if (cnt[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_resume got count=%0d want 1", cnt[0]);
        end
        idle();
    endtask

    task automatic test_toggle();
        idle();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < 3; i++) begin
                e[i] = (c % 2 == 0);
                u[i] = ((c / 2) % 2 == 0);
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (cnt[i] !== 4'(mc[i]) || lim[i] !== ml[i] ||
                    zr[i] !== (mc[i] == 0) || mx[i] !== (mc[i] == mod[i] - 1)) begin
                    n_fail++;
                    $display("FAIL toggle cyc %0d dut%0d got count=%0d limit=%b want %0d/%b",
                             c, i, cnt[i], lim[i], mc[i], ml[i]);
                end
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 3; i++) begin
                l[i]  = ($urandom_range(0, 7) == 0);
                e[i]  = ($urandom_range(0, 3) != 0);
                u[i]  = $urandom_range(0, 1) != 0;
                lv[i] = 4'($urandom_range(0, 15));
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (cnt[i] !== 4'(mc[i]) || lim[i] !== ml[i] ||
                    zr[i] !== (mc[i] == 0) || mx[i] !== (mc[i] == mod[i] - 1)) begin
                    n_fail++;
                    $display("FAIL random cyc %0d dut%0d got count=%0d limit=%b zero=%b max=%b want %0d/%b",
                             c, i, cnt[i], lim[i], zr[i], mx[i], mc[i], ml[i]);
                end
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        for (int i = 0; i < 3; i++) begin mc[i] = 0; ml[i] = 1'b0; end
        test_reset();
        test_down_wrap();
        test_up_mod10();
        test_saturate();
        test_load();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
